// File: rtl/keypad_pkg.sv
// ============================================================================
// Module  : keypad_pkg
// Purpose : Shared types, key-code constants and helpers for the keypad
//           receive path (state encoding, row/column to key-code decoding,
//           single-row detection).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Map a (row, column) position on the 4x4 pad to its key code.
  function automatic logic [3:0] decode_key(input logic [1:0] row,
                                            input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // True when exactly one row line is active; two or more means ghosting.
  function automatic logic single_row(input logic [3:0] rows);
    logic result;
    result = 1'b0;
    case (rows)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: result = 1'b1;
      default:                            result = 1'b0;
    endcase
    return result;
  endfunction

  // Index of the active row; only meaningful when single_row() is true.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    case (rows)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/row_sync.sv
// ============================================================================
// Module  : row_sync
// Purpose : N-stage flip-flop chain with asynchronous active-high reset.
//           Used as the row-input synchroniser and as the matching delay
//           line for the column index so both arrive aligned.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset
//           d    - input vector [WIDTH-1:0]
//           q    - output after STAGES clocks [WIDTH-1:0]
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module row_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/keypad_row_decoder.sv
// ============================================================================
// Module  : keypad_row_decoder
// Purpose : Receive side of a 4x4 keypad scan. Synchronises the row lines,
//           aligns them with the driven column index, debounces one key at
//           a time and reports its code with a single-cycle strobe plus a
//           held flag that drops on a debounced release.
// Ports   : slow_clk     - scan clock, shared with the column driver
//           rst          - asynchronous active-high reset
//           row_in[3:0]  - raw row lines for the currently driven column
//           column_index - index of the column driven this cycle
//           key_code     - code of the last accepted key
//           key_valid    - one-cycle pulse on press acceptance
//           key_held     - high from press acceptance to release acceptance
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_row_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int RELEASE_SCANS  = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic [1:0] column_index,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] REL_TARGET = 4'(RELEASE_SCANS);

  logic [3:0] row_s;
  logic [1:0] col_s;

  row_sync #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_row_sync (
    .clk (slow_clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  // Same depth as the row synchroniser so each row sample is paired with
  // the column that was driven when it was captured.
  row_sync #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_col_delay (
    .clk (slow_clk),
    .rst (rst),
    .d   (column_index),
    .q   (col_s)
  );

  key_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] row_cap_q, row_cap_d;
  logic [1:0] col_cap_q, col_cap_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;

  logic       hit;
  logic [1:0] hit_row;
  logic       col_match;
  logic [3:0] cnt_inc;
  logic       accept;

  assign hit       = single_row(row_s);
  assign hit_row   = row_index(row_s);
  assign col_match = (col_s == col_cap_q);
  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_cap_d   = row_cap_q;
    col_cap_d   = col_cap_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          row_cap_d = hit_row;
          col_cap_d = col_s;
          if (DEB_TARGET == 4'd1) begin
            accept = 1'b1;
          end else begin
            cnt_d   = 4'd1;
            state_d = DEBOUNCE;
          end
        end
      end

      DEBOUNCE: begin
        // Cycles scanning other columns carry no information about this key.
        if (col_match) begin
          if (hit && (hit_row == row_cap_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_TARGET) begin
              accept = 1'b1;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
      end

      PRESSED: begin
        // Only the captured key's row bit matters; other keys are ignored.
        if (col_match && !row_s[row_cap_q]) begin
          if (REL_TARGET == 4'd1) begin
            key_held_d = 1'b0;
            cnt_d      = 4'd0;
            state_d    = IDLE;
          end else begin
            cnt_d   = 4'd1;
            state_d = RELEASE;
          end
        end
      end

      RELEASE: begin
        if (col_match) begin
          if (!row_s[row_cap_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == REL_TARGET) begin
              key_held_d = 1'b0;
              cnt_d      = 4'd0;
              state_d    = IDLE;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = PRESSED;
          end
        end
      end

      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      key_code_d  = decode_key(row_cap_d, col_cap_d);
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      cnt_d       = 4'd0;
      state_d     = PRESSED;
    end
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      row_cap_q   <= 2'd0;
      col_cap_q   <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_cap_q   <= row_cap_d;
      col_cap_q   <= col_cap_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_row_decoder.sv
// ============================================================================
// Module  : tb_keypad_row_decoder
// Purpose : Scoreboard bench for keypad_row_decoder. A keypad model turns a
//           16-bit pressed-key mask into row lines for a rotating column
//           index; expected key codes are queued as presses are issued and
//           a monitor pops and compares them on every key_valid strobe.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_row_decoder;

  logic       slow_clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [1:0] column_index;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_row_decoder #(
    .DEBOUNCE_SCANS (4),
    .RELEASE_SCANS  (4),
    .SYNC_STAGES    (2)
  ) dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .row_in       (row_in),
    .column_index (column_index),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held)
  );

  always #5 slow_clk = ~slow_clk;

  // Key mask bit = row*4 + col.
  localparam int K1    = 0;
  localparam int KA    = 3;
  localparam int K4    = 4;
  localparam int K5    = 5;
  localparam int K7    = 8;
  localparam int KHASH = 14;
  localparam int KD    = 15;

  logic [15:0] keys;
  logic [1:0]  col_cnt;
  logic [3:0]  sb [$];
  logic [3:0]  mon_exp;
  int          n_vec;
  int          n_err;
  int          cyc;
  int          valid_cyc;
  int          t_apply;
  int          lat;
  int          got;

  always @(posedge slow_clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One scan-clock cycle of the column driver plus the keypad matrix.
  task automatic tick();
    @(negedge slow_clk);
    column_index = col_cnt;
    row_in = {keys[12 + int'(col_cnt)], keys[8 + int'(col_cnt)],
              keys[4 + int'(col_cnt)],  keys[int'(col_cnt)]};
    col_cnt = col_cnt + 2'd1;
  endtask

  task automatic scans(input int n);
    repeat (4 * n) tick();
  endtask

  // Async reset pulse inside the low clock phase, outputs checked at once.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_code"},  int'(key_code),  0);
    check({tag, "_valid"}, int'(key_valid), 0);
    check({tag, "_held"},  int'(key_held),  0);
    #1 rst = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge slow_clk) begin
    if (!rst && key_valid) begin
      valid_cyc = cyc;
      if (sb.size() == 0) begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_pulse: key_code=%h, no pulse expected", key_code);
      end else begin
        mon_exp = sb.pop_front();
        check("pulse_code", int'(key_code), int'(mon_exp));
        check("pulse_held", int'(key_held), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; valid_cyc = 0;
    keys = 16'h0; col_cnt = 2'd0;
    row_in = 4'h0; column_index = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge slow_clk);
    @(negedge slow_clk);
    check("rst_code",  int'(key_code),  0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held",  int'(key_held),  0);
    rst = 1'b0;

    // '5' held for 40 cycles; only driven while column 1 is scanned.
    sb.push_back(4'h5);
    keys = 16'h0; keys[K5] = 1'b1;
    tick();
    tick();
    t_apply = cyc + 1;
    repeat (38) tick();
    check("k5_pulse_seen", sb.size(), 0);
    lat = valid_cyc - t_apply;
    check("k5_latency_le_19", int'(lat >= 1 && lat <= 19), 1);
    check("k5_held", int'(key_held), 1);
    keys = 16'h0;
    scans(6);
    check("k5_released", int'(key_held), 0);

    // '#' with a bounce: hits on observations 1-2, miss on 3, hits from 4.
    sb.push_back(4'hF);
    keys = 16'h0; keys[KHASH] = 1'b1;
    scans(2);
    keys = 16'h0;
    scans(1);
    keys[KHASH] = 1'b1;
    scans(3);
    check("hash_no_early_pulse", sb.size(), 1);
    scans(4);
    check("hash_pulse_seen", sb.size(), 0);
    check("hash_code", int'(key_code), 15);

    // Release of '#': 3 empty, 1 present, then 4 empty observations.
    keys = 16'h0;
    scans(3);
    keys[KHASH] = 1'b1;
    scans(1);
    check("hash_held_after_gap", int'(key_held), 1);
    keys = 16'h0;
    scans(4);
    check("hash_held_before_4th", int'(key_held), 1);
    scans(1);
    check("hash_released", int'(key_held), 0);
    check("hash_code_kept", int'(key_code), 15);

    // Ghosting: '1' and '4' together in column 0 are rejected.
    keys = 16'h0; keys[K1] = 1'b1; keys[K4] = 1'b1;
    scans(6);
    check("ghost_no_held", int'(key_held), 0);
    sb.push_back(4'h4);
    keys[K1] = 1'b0;
    scans(6);
    check("k4_pulse_seen", sb.size(), 0);
    check("k4_held", int'(key_held), 1);
    keys = 16'h0;
    scans(6);
    check("k4_released", int'(key_held), 0);

    // No rollover: '7' pressed while 'A' held is ignored until 'A' releases.
    sb.push_back(4'hA);
    keys = 16'h0; keys[KA] = 1'b1;
    scans(6);
    check("ka_pulse_seen", sb.size(), 0);
    keys[K7] = 1'b1;
    scans(8);
    check("ka_k7_no_second", int'(key_code), 10);
    check("ka_k7_held", int'(key_held), 1);
    sb.push_back(4'h7);
    keys[KA] = 1'b0;
    scans(12);
    check("k7_pulse_seen", sb.size(), 0);
    check("k7_code", int'(key_code), 7);
    keys = 16'h0;
    scans(6);
    check("k7_released", int'(key_held), 0);

    // Reset during debounce of 'D', then a fresh debounce.
    keys = 16'h0; keys[KD] = 1'b1;
    scans(2);
    reset_pulse("rst_deb");
    tick();
    tick();
    sb.push_back(4'hD);
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      tick();
      if (key_valid) got = 1;
    end
    check("kd_pulse_in_time", got, 1);

    // Reset during the key_valid cycle itself.
    reset_pulse("rst_pulse");
    tick();
    tick();
    sb.push_back(4'hD);
    scans(7);
    check("kd_again_seen", sb.size(), 0);
    check("kd_again_code", int'(key_code), 13);
    check("kd_again_held", int'(key_held), 1);
    keys = 16'h0;
    scans(6);
    check("kd_released", int'(key_held), 0);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
